// File: rtl/regfile_dump_pkg.sv
// Shared FSM state encodings and constants for the register-file dump reader.
package regfile_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HALT_WAIT = 3'd1,
    ST_LOAD      = 3'd2,
    ST_SEND      = 3'd3,
    ST_FIN       = 3'd4
  } state_e;

  // Index reported on the beat that carries the program counter.
  localparam logic [5:0] DUMP_PC_INDEX = 6'd32;

endpackage

// File: rtl/regfile_dump.sv
// Debug reader: halts the core, then streams every register as an (index, data) beat.
// Optional build macro REGFILE_DUMP_PC_EN appends a final beat carrying the PC.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int NREG       = 32,
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int INCLUDE_R0 = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Abort,
  output logic          HaltReq,
  input  logic          HaltAck,
  output logic [AW-1:0] RdAddr,
  input  logic [DW-1:0] RdData,
  input  logic [DW-1:0] PC,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [AW:0]   OutIndex,
  output logic [DW-1:0] OutData,
  output logic          OutLast,
  output logic          Busy,
  output logic          Done
);

  localparam int IW = AW + 1;
  localparam logic [IW-1:0] FIRST_IDX = (INCLUDE_R0 != 0) ? {IW{1'b0}} : IW'(1'b1);
  localparam logic [IW-1:0] REG_LAST  = IW'(NREG - 1);
`ifdef REGFILE_DUMP_PC_EN
  localparam logic [IW-1:0] PC_IDX    = IW'(DUMP_PC_INDEX);
  localparam logic [IW-1:0] LAST_IDX  = PC_IDX;
`else
  localparam logic [IW-1:0] LAST_IDX  = REG_LAST;
`endif

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [AW-1:0] rd_addr_q;
  logic          halt_req_q;
  logic          out_valid_q;
  logic [IW-1:0] out_index_q;
  logic [DW-1:0] out_data_q;
  logic          out_last_q;
  logic          busy_q;
  logic          done_q;

  logic          accept_s;
  logic [IW-1:0] next_idx_s;
  logic [DW-1:0] load_data_s;

`ifndef REGFILE_DUMP_PC_EN
  logic unused_pc_s;
  assign unused_pc_s = ^PC;
`endif

  // Handshake decode, next scan index and the value captured in LOAD.
  always_comb begin
    accept_s   = (state_q == ST_SEND) && out_valid_q && OutReady;
    next_idx_s = idx_q + IW'(1'b1);
    if (idx_q == {IW{1'b0}}) begin
      load_data_s = {DW{1'b0}};
    end else begin
      load_data_s = RdData;
    end
`ifdef REGFILE_DUMP_PC_EN
    if (idx_q == REG_LAST) begin
      next_idx_s = PC_IDX;
    end else begin
      next_idx_s = idx_q + IW'(1'b1);
    end
    if (idx_q == PC_IDX) begin
      load_data_s = PC;
    end else begin
      load_data_s = load_data_s;
    end
`endif
  end

  // Dump FSM with the scan counter and all registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= {IW{1'b0}};
      rd_addr_q   <= {AW{1'b0}};
      halt_req_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_index_q <= {IW{1'b0}};
      out_data_q  <= {DW{1'b0}};
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (Abort) begin
      // Cancel wins over everything, including a pending beat and a same-cycle Start.
      state_q     <= ST_IDLE;
      idx_q       <= {IW{1'b0}};
      rd_addr_q   <= {AW{1'b0}};
      halt_req_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (Start) begin
            state_q    <= ST_HALT_WAIT;
            idx_q      <= FIRST_IDX;
            halt_req_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_HALT_WAIT: begin
          if (HaltAck) begin
            state_q   <= ST_LOAD;
            rd_addr_q <= idx_q[AW-1:0];
          end
        end
        ST_LOAD: begin
          out_data_q  <= load_data_s;
          out_index_q <= idx_q;
          out_last_q  <= (idx_q == LAST_IDX);
          out_valid_q <= 1'b1;
          state_q     <= ST_SEND;
        end
        ST_SEND: begin
          if (accept_s) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              state_q   <= ST_FIN;
              rd_addr_q <= {AW{1'b0}};
              done_q    <= 1'b1;
            end else begin
              state_q   <= ST_LOAD;
              idx_q     <= next_idx_s;
              rd_addr_q <= next_idx_s[AW-1:0];
            end
          end
        end
        ST_FIN: begin
          state_q    <= ST_IDLE;
          halt_req_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          idx_q       <= {IW{1'b0}};
          rd_addr_q   <= {AW{1'b0}};
          halt_req_q  <= 1'b0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign HaltReq  = halt_req_q;
  assign RdAddr   = rd_addr_q;
  assign OutValid = out_valid_q;
  assign OutIndex = out_index_q;
  assign OutData  = out_data_q;
  assign OutLast  = out_last_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: scoreboard of expected beats against a beat monitor.
module tb_regfile_dump;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;
`ifdef REGFILE_DUMP_PC_EN
  localparam bit PC_EN_B = 1'b1;
  localparam int NBEATS  = NREG + 1;
`else
  localparam bit PC_EN_B = 1'b0;
  localparam int NBEATS  = NREG;
`endif
  localparam logic [DW-1:0] PC_VAL = 32'h0040_0018;

  logic          Clk      = 1'b0;
  logic          Reset    = 1'b1;
  logic          Start    = 1'b0;
  logic          Abort    = 1'b0;
  logic          OutReady = 1'b1;
  logic          HaltReq, HaltAck, OutValid, OutLast, Busy, Done;
  logic [AW-1:0] RdAddr;
  logic [DW-1:0] RdData, PC, OutData;
  logic [AW:0]   OutIndex;
  logic          ack_tie  = 1'b1;
  logic          ack_man  = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [38:0] exp_q[$];
  logic [38:0] obs_mem [0:511];
  int obs_n = 0;

  always #5 Clk = ~Clk;

  assign HaltAck = ack_tie ? HaltReq : ack_man;
  assign RdData  = (RdAddr == 5'd0) ? 32'd0 : (32'h1000_0000 + {27'd0, RdAddr});
  assign PC      = PC_VAL;

  regfile_dump #(.NREG(NREG), .AW(AW), .DW(DW), .INCLUDE_R0(1)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
    .HaltReq(HaltReq), .HaltAck(HaltAck), .RdAddr(RdAddr), .RdData(RdData),
    .PC(PC), .OutValid(OutValid), .OutReady(OutReady), .OutIndex(OutIndex),
    .OutData(OutData), .OutLast(OutLast), .Busy(Busy), .Done(Done)
  );

  // Records every beat the sink accepts on the coming edge.
  always @(negedge Clk) begin
    if (!Reset && !Abort && OutValid && OutReady && obs_n < 512) begin
      obs_mem[obs_n] <= {OutLast, OutIndex, OutData};
      obs_n <= obs_n + 1;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_beats(input int n, input bit full);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({(full && !PC_EN_B && k == NREG - 1), 6'(k),
                       (k == 0) ? 32'd0 : (32'h1000_0000 + 32'(k))});
    end
    if (full && PC_EN_B) exp_q.push_back({1'b1, 6'd32, PC_VAL});
  endtask

  task automatic test_reset();
    @(negedge Clk);
    checks++;
    if ({HaltReq, RdAddr, OutValid, OutIndex, OutData, OutLast, Busy, Done} !== 47'd0) begin
      errors++;
      $display("FAIL reset_values got %h exp 0", {HaltReq, RdAddr, OutValid, OutIndex, OutData, OutLast, Busy, Done});
    end
    tick();
    Reset = 1'b0;
    tick();
    checks++;
    if ({HaltReq, OutValid, Busy, Done} !== 4'd0) begin
      errors++;
      $display("FAIL reset_release got %b exp 0000", {HaltReq, OutValid, Busy, Done});
    end
  endtask

  task automatic test_full_dump();
    int n;
    int base;
    logic [38:0] e;
    base = obs_n;
    push_beats(NREG, 1'b1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    checks++;
    if ({HaltReq, Busy} !== 2'b11) begin
      errors++;
      $display("FAIL full_halt_start got %b exp 11", {HaltReq, Busy});
    end
    n = 0;
    while (Done !== 1'b1 && n < 300) begin tick(); n++; end
    checks++;
    if (n + 1 != 2 + 2 * NBEATS) begin
      errors++;
      $display("FAIL full_cycles got %0d exp %0d", n + 1, 2 + 2 * NBEATS);
    end
    tick();
    checks++;
    if ({Done, Busy, HaltReq, OutValid} !== 4'd0) begin
      errors++;
      $display("FAIL full_after_done got %b exp 0000", {Done, Busy, HaltReq, OutValid});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (base >= obs_n) begin
        errors++;
        $display("FAIL full_beat got none exp %h", e);
      end else begin
        if (obs_mem[base] !== e) begin
          errors++;
          $display("FAIL full_beat got %h exp %h", obs_mem[base], e);
        end
        base++;
      end
    end
    checks++;
    if (base != obs_n) begin
      errors++;
      $display("FAIL full_extra got %0d beats exp %0d", obs_n - base, 0);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int base;
    logic [38:0] e;
    base = obs_n;
    push_beats(NREG, 1'b1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    n = 0;
    while (!(OutValid === 1'b1 && OutIndex === 6'd7) && n < 100) begin tick(); n++; end
    OutReady = 1'b0;
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL bp_reach got timeout exp beat 7");
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({OutValid, OutIndex, OutData, RdAddr, HaltReq} !== {1'b1, 6'd7, 32'h1000_0007, 5'd7, 1'b1}) begin
        errors++;
        $display("FAIL bp_hold got %h exp %h", {OutValid, OutIndex, OutData, RdAddr, HaltReq},
                 {1'b1, 6'd7, 32'h1000_0007, 5'd7, 1'b1});
      end
    end
    OutReady = 1'b1;
    tick();
    checks++;
    if (OutValid !== 1'b0) begin
      errors++;
      $display("FAIL bp_gap got %b exp 0", OutValid);
    end
    tick();
    checks++;
    if ({OutValid, OutIndex} !== {1'b1, 6'd8}) begin
      errors++;
      $display("FAIL bp_next got %h exp %h", {OutValid, OutIndex}, {1'b1, 6'd8});
    end
    n = 0;
    while (Done !== 1'b1 && n < 300) begin tick(); n++; end
    checks++;
    if (Done !== 1'b1) begin
      errors++;
      $display("FAIL bp_done got timeout exp Done");
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (base >= obs_n) begin
        errors++;
        $display("FAIL bp_beat got none exp %h", e);
      end else begin
        if (obs_mem[base] !== e) begin
          errors++;
          $display("FAIL bp_beat got %h exp %h", obs_mem[base], e);
        end
        base++;
      end
    end
    checks++;
    if (base != obs_n) begin
      errors++;
      $display("FAIL bp_extra got %0d beats exp 0", obs_n - base);
    end
    tick();
  endtask

  task automatic test_halt_delay();
    int n;
    int base;
    logic [38:0] e;
    ack_tie = 1'b0;
    ack_man = 1'b0;
    base = obs_n;
    push_beats(NREG, 1'b1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({OutValid, RdAddr, HaltReq, Busy} !== {1'b0, 5'd0, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL halt_wait got %b exp %b", {OutValid, RdAddr, HaltReq, Busy}, {1'b0, 5'd0, 1'b1, 1'b1});
      end
      tick();
    end
    ack_man = 1'b1;
    tick();
    ack_tie = 1'b1;
    ack_man = 1'b0;
    n = 0;
    while (Done !== 1'b1 && n < 300) begin tick(); n++; end
    checks++;
    if (Done !== 1'b1) begin
      errors++;
      $display("FAIL halt_done got timeout exp Done");
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (base >= obs_n) begin
        errors++;
        $display("FAIL halt_beat got none exp %h", e);
      end else begin
        if (obs_mem[base] !== e) begin
          errors++;
          $display("FAIL halt_beat got %h exp %h", obs_mem[base], e);
        end
        base++;
      end
    end
    checks++;
    if (base != obs_n) begin
      errors++;
      $display("FAIL halt_extra got %0d beats exp 0", obs_n - base);
    end
    tick();
  endtask

  task automatic test_abort();
    int n;
    int base;
    logic [38:0] e;
    base = obs_n;
    push_beats(12, 1'b0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    n = 0;
    while (!(OutValid === 1'b1 && OutIndex === 6'd12) && n < 100) begin tick(); n++; end
    OutReady = 1'b0;
    tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    checks++;
    if ({OutValid, HaltReq, Busy, Done} !== 4'd0) begin
      errors++;
      $display("FAIL abort_drop got %b exp 0000", {OutValid, HaltReq, Busy, Done});
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({Done, Busy} !== 2'b00) begin
        errors++;
        $display("FAIL abort_no_done got %b exp 00", {Done, Busy});
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (base >= obs_n) begin
        errors++;
        $display("FAIL abort_beat got none exp %h", e);
      end else begin
        if (obs_mem[base] !== e) begin
          errors++;
          $display("FAIL abort_beat got %h exp %h", obs_mem[base], e);
        end
        base++;
      end
    end
    checks++;
    if (base != obs_n) begin
      errors++;
      $display("FAIL abort_extra got %0d beats exp 0", obs_n - base);
    end
    OutReady = 1'b1;
    push_beats(NREG, 1'b1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    n = 0;
    while (Done !== 1'b1 && n < 300) begin tick(); n++; end
    checks++;
    if (Done !== 1'b1) begin
      errors++;
      $display("FAIL abort_redump got timeout exp Done");
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (base >= obs_n) begin
        errors++;
        $display("FAIL abort_redump_beat got none exp %h", e);
      end else begin
        if (obs_mem[base] !== e) begin
          errors++;
          $display("FAIL abort_redump_beat got %h exp %h", obs_mem[base], e);
        end
        base++;
      end
    end
    checks++;
    if (base != obs_n) begin
      errors++;
      $display("FAIL abort_redump_extra got %0d beats exp 0", obs_n - base);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    int base;
    logic [38:0] e;
    base = obs_n;
    push_beats(20, 1'b0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    n = 0;
    while (!(OutValid === 1'b1 && OutIndex === 6'd20) && n < 100) begin tick(); n++; end
    Reset = 1'b1;
    #1;
    checks++;
    if ({HaltReq, RdAddr, OutValid, OutIndex, OutData, OutLast, Busy, Done} !== 47'd0) begin
      errors++;
      $display("FAIL reset_async got %h exp 0", {HaltReq, RdAddr, OutValid, OutIndex, OutData, OutLast, Busy, Done});
    end
    tick();
    tick();
    Reset = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (base >= obs_n) begin
        errors++;
        $display("FAIL reset_beat got none exp %h", e);
      end else begin
        if (obs_mem[base] !== e) begin
          errors++;
          $display("FAIL reset_beat got %h exp %h", obs_mem[base], e);
        end
        base++;
      end
    end
    checks++;
    if (base != obs_n) begin
      errors++;
      $display("FAIL reset_extra got %0d beats exp 0", obs_n - base);
    end
    tick();
    push_beats(NREG, 1'b1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    n = 0;
    while (Done !== 1'b1 && n < 300) begin
      Start = (n % 9 == 4) ? 1'b1 : 1'b0;
      tick();
      n++;
    end
    Start = 1'b0;
    checks++;
    if (n + 1 != 2 + 2 * NBEATS) begin
      errors++;
      $display("FAIL busy_start_cycles got %0d exp %0d", n + 1, 2 + 2 * NBEATS);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({Busy, HaltReq, OutValid} !== 3'b000) begin
        errors++;
        $display("FAIL busy_start_idle got %b exp 000", {Busy, HaltReq, OutValid});
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (base >= obs_n) begin
        errors++;
        $display("FAIL busy_start_beat got none exp %h", e);
      end else begin
        if (obs_mem[base] !== e) begin
          errors++;
          $display("FAIL busy_start_beat got %h exp %h", obs_mem[base], e);
        end
        base++;
      end
    end
    checks++;
    if (base != obs_n) begin
      errors++;
      $display("FAIL busy_start_extra got %0d beats exp 0", obs_n - base);
    end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_halt_delay();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
